// File: rtl/timing_pkg.sv
// Shared constants for the drum timing sequencer: drum geometry, timing ROM
// bit positions and the sequencer FSM state encoding.
package timing_pkg;

  localparam int DRUM_POSITIONS = 64;
  localparam int TERM_ADDR      = 59;

  // Bit positions inside one timing ROM word.
  localparam int ROM_W           = 7;
  localparam int READ            = 0;
  localparam int WRITE           = 1;
  localparam int LAST_READ       = 2;
  localparam int LAST_WRITE      = 3;
  localparam int CHECK_INPUTS    = 4;
  localparam int CLEAR_CARRY     = 5;
  localparam int RESET_COUNTER_N = 6;

  // Sequencer FSM states, kept as plain constants so older flows can use them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PRIME  = 3'd1;
  localparam state_t ST_RUN    = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

endpackage

// File: rtl/drum_position_counter.sv
// Drum position register: steps one position per advance, returns to 0 on the
// end-of-revolution marker or on a 63->0 wrap, and keeps a sticky error flag
// for markers seen off the terminal position or revolutions with no marker.
module drum_position_counter #(
  parameter int ADDR_W    = 6,
  parameter int TERM_ADDR = 59
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,     // force position 0 (start/abort)
  input  logic              advance_i,   // RUN and not paused: step and sample marker
  input  logic              marker_n_i,  // resetCounter_n from the ROM, active low
  input  logic              err_clr_i,   // clear sticky error (new run accepted)
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrap_o,      // a revolution ends this cycle
  output logic              wrap_err_o
);

  localparam logic [ADDR_W-1:0] TERM_POS = ADDR_W'(TERM_ADDR);
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_err_q, wrap_err_d;
  logic              at_last;
  logic              err_now;

  // Revolution boundary, error detection and next position.
  always_comb begin
    at_last    = (addr_q == {ADDR_W{1'b1}});
    wrap_o     = advance_i & (~marker_n_i | at_last);
    err_now    = advance_i & ((~marker_n_i & (addr_q != TERM_POS)) |
                              (marker_n_i & at_last));
    addr_d     = addr_q;
    if (clear_i)         addr_d = '0;
    else if (wrap_o)     addr_d = '0;
    else if (advance_i)  addr_d = addr_q + ONE;
    wrap_err_d = err_clr_i ? 1'b0 : (wrap_err_q | err_now);
  end

  // Position and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wrap_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wrap_err_q <= wrap_err_d;
    end
  end

  assign addr_o     = addr_q;
  assign wrap_err_o = wrap_err_q;

endmodule

// File: rtl/drum_timing_sequencer.sv
// Drum timing sequencer: walks the timing ROM one position per clock, counts
// revolutions by the resetCounter_n marker and runs a requested number of
// revolutions under start/busy/done with pause and abort.
// Handshake: start is taken only in IDLE (and not with abort); busy is high
// from the cycle after an accepted start until the FINISH cycle, where done
// pulses for one cycle, or until abort returns the FSM to IDLE.
module drum_timing_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int REV_W     = 8,
  parameter int TERM_ADDR = 59
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REV_W-1:0]  num_revs,
  input  logic              pause,
  input  logic              abort,
  input  logic              reset_counter_n,
  input  logic              check_inputs,
  output logic [ADDR_W-1:0] addr,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              busy,
  output logic              done,
  output logic [REV_W-1:0]  rev_count,
  output logic              input_strobe,
  output logic              wrap_err,
  output logic [2:0]        dbg_state
);
  import timing_pkg::*;

  localparam logic [REV_W-1:0] REV_ONE = {{(REV_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [REV_W-1:0] target_q, target_d;
  logic [REV_W-1:0] rev_q, rev_d, rev_inc;
  logic             strobe_q, strobe_d;
  logic             accept, advance, clear_addr, wrap, last_rev;

  drum_position_counter #(
    .ADDR_W   (ADDR_W),
    .TERM_ADDR(TERM_ADDR)
  ) u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_addr),
    .advance_i (advance),
    .marker_n_i(reset_counter_n),
    .err_clr_i (accept),
    .addr_o    (addr),
    .wrap_o    (wrap),
    .wrap_err_o(wrap_err)
  );

  // Control decode: abort beats pause, pause beats the marker.
  always_comb begin
    accept     = (state_q == ST_IDLE) && start && !abort;
    advance    = (state_q == ST_RUN) && !abort && !pause;
    clear_addr = accept || (abort && (state_q != ST_IDLE));
    rev_inc    = rev_q + REV_ONE;
    last_rev   = advance && wrap && (rev_inc == target_q);
    target_d   = target_q;
    rev_d      = rev_q;
    if (accept) begin
      target_d = (num_revs == '0) ? REV_ONE : num_revs;
      rev_d    = '0;
    end else if (advance && wrap) begin
      rev_d    = rev_inc;
    end
    strobe_d   = advance && check_inputs;
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_PRIME;
      ST_PRIME:  state_d = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort)         state_d = ST_IDLE;
        else if (pause)    state_d = ST_HOLD;
        else if (last_rev) state_d = ST_FINISH;
      end
      ST_HOLD: begin
        if (abort)         state_d = ST_IDLE;
        else if (!pause)   state_d = ST_RUN;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= REV_ONE;
      rev_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rev_q    <= rev_d;
      strobe_q <= strobe_d;
    end
  end

  // ROM enables and status decoded from the registered state.
  always_comb begin
    ce_n = !((state_q == ST_PRIME) || (state_q == ST_RUN) || (state_q == ST_HOLD));
    oe_n = !((state_q == ST_PRIME) || (state_q == ST_RUN));
    busy = (state_q == ST_PRIME) || (state_q == ST_RUN) || (state_q == ST_HOLD);
    done = (state_q == ST_FINISH);
  end

  assign we_n         = 1'b1;
  assign rev_count    = rev_q;
  assign input_strobe = strobe_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_drum_timing_sequencer.sv
// Bench for drum_timing_sequencer: a model timing ROM, a table of full runs
// checked through an expected-result queue, and hand sequences for reset,
// pause and abort corner cases.
module tb_drum_timing_sequencer;
  import timing_pkg::*;

  localparam int ADDR_W = 6;
  localparam int REV_W  = 8;
  localparam int SB_W   = 25;  // {done_cycle[15:0], rev_count[7:0], wrap_err}

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [REV_W-1:0]  num_revs = '0;
  logic              pause = 1'b0;
  logic              abort = 1'b0;
  logic              reset_counter_n;
  logic              check_inputs;
  logic [ADDR_W-1:0] addr;
  logic              ce_n, oe_n, we_n, busy, done, input_strobe, wrap_err;
  logic [REV_W-1:0]  rev_count;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  drum_timing_sequencer #(.ADDR_W(ADDR_W), .REV_W(REV_W), .TERM_ADDR(59)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_revs(num_revs),
    .pause(pause), .abort(abort), .reset_counter_n(reset_counter_n),
    .check_inputs(check_inputs), .addr(addr), .ce_n(ce_n), .oe_n(oe_n),
    .we_n(we_n), .busy(busy), .done(done), .rev_count(rev_count),
    .input_strobe(input_strobe), .wrap_err(wrap_err), .dbg_state(dbg_state)
  );

  // Model timing ROM, read combinationally by position.
  logic [ROM_W-1:0] rom [DRUM_POSITIONS];
  assign reset_counter_n = rom[addr][RESET_COUNTER_N];
  assign check_inputs    = rom[addr][CHECK_INPUTS];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [SB_W-1:0] exp_q[$];

  typedef struct {
    int num;       // num_revs requested
    int marker;    // marker position, 64 = no marker
    int exp_done;  // cycle of done, counted from the PRIME cycle as 0
    int exp_rev;
    int exp_err;
  } vec_t;
  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_rom(input int marker);
    for (int i = 0; i < DRUM_POSITIONS; i++) begin
      rom[i]                  = '0;
      rom[i][READ]            = i[0];
      rom[i][WRITE]           = ~i[0];
      rom[i][RESET_COUNTER_N] = (i != marker);
      rom[i][CHECK_INPUTS]    = ((i % 5) == 2);
    end
  endtask

  task automatic wait_pos(input int a, input int revs, input string name);
    int n;
    n = 0;
    while (!(int'(addr) == a && int'(rev_count) == revs) && n < 400) begin
      tick();
      n++;
    end
    check(name, int'(addr), a);
  endtask

  task automatic run_vec(input vec_t v);
    int len, cyc, bad_a, bad_s, exp_s;
    logic [SB_W-1:0] e;
    load_rom(v.marker);
    len = (v.marker < DRUM_POSITIONS) ? v.marker + 1 : DRUM_POSITIONS;
    num_revs = REV_W'(v.num);
    start = 1'b1;
    exp_q.push_back({16'(v.exp_done), 8'(v.exp_rev), 1'(v.exp_err)});
    tick();
    start = 1'b0;
    num_revs = REV_W'($urandom_range(255));  // must not matter after latch
    check("prime_state", int'(dbg_state), int'(ST_PRIME));
    check("prime_oe_n", int'(oe_n), 0);
    check("prime_busy", int'(busy), 1);
    check("prime_wrap_err", int'(wrap_err), 0);
    cyc = 0; bad_a = 0; bad_s = 0;
    while (done !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
      exp_s = (cyc >= 2) ? int'(rom[(cyc - 2) % len][CHECK_INPUTS]) : 0;
      if (int'(input_strobe) != exp_s) bad_s++;
      if (done !== 1'b1 && int'(addr) != (cyc - 1) % len) bad_a++;
    end
    check("addr_sequence_errors", bad_a, 0);
    check("strobe_sequence_errors", bad_s, 0);
    e = exp_q.pop_front();
    check("done_cycle", cyc, int'(e[24:9]));
    check("final_rev_count", int'(rev_count), int'(e[8:1]));
    check("final_wrap_err", int'(wrap_err), int'(e[0]));
    check("finish_busy", int'(busy), 0);
    check("finish_addr", int'(addr), 0);
    tick();
    check("done_single_pulse", int'(done), 0);
    check("after_finish_state", int'(dbg_state), int'(ST_IDLE));
    check("rev_count_retained", int'(rev_count), int'(e[8:1]));
    repeat (3) tick();
    check("wrap_err_sticky", int'(wrap_err), int'(e[0]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{2, 59, 121, 2, 0};
    vecs[1] = '{0, 59,  61, 1, 0};
    vecs[2] = '{1, 40,  42, 1, 1};
    vecs[3] = '{3, 59, 181, 3, 0};
    vecs[4] = '{3, 40, 124, 3, 1};
    vecs[5] = '{1, 64,  65, 1, 1};
    vecs[6] = '{2, 64, 129, 2, 1};
    vecs[7] = '{1,  0,   2, 1, 1};

    load_rom(59);
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    check("rst_addr", int'(addr), 0);
    check("rst_ce_n", int'(ce_n), 1);
    check("rst_oe_n", int'(oe_n), 1);
    check("rst_we_n", int'(we_n), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rev_count", int'(rev_count), 0);
    check("rst_strobe", int'(input_strobe), 0);
    check("rst_wrap_err", int'(wrap_err), 0);
    rst_n = 1'b1;
    tick();

    // Table of complete runs.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a run, with wrap_err already set.
    load_rom(40);
    num_revs = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_pos(30, 1, "midrun_reach_30");
    check("midrun_wrap_err_set", int'(wrap_err), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun_rst_addr", int'(addr), 0);
    check("midrun_rst_ce_n", int'(ce_n), 1);
    check("midrun_rst_oe_n", int'(oe_n), 1);
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_wrap_err", int'(wrap_err), 0);
    check("midrun_rst_rev", int'(rev_count), 0);
    tick();
    check("midrun_rst_idle", int'(dbg_state), int'(ST_IDLE));

    // Pause before the marker, then pause on the marker itself.
    load_rom(59);
    rom[58][CHECK_INPUTS] = 1'b1;
    num_revs = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_pos(58, 0, "pause_reach_58");
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);  // start while busy must be ignored
      tick();
      check("hold_addr", int'(addr), 58);
      check("hold_oe_n", int'(oe_n), 1);
      check("hold_ce_n", int'(ce_n), 0);
      check("hold_strobe", int'(input_strobe), 0);
      check("hold_state", int'(dbg_state), int'(ST_HOLD));
    end
    start = 1'b0;
    pause = 1'b0;
    tick();
    check("resume_addr", int'(addr), 58);
    check("resume_state", int'(dbg_state), int'(ST_RUN));
    tick();
    check("resume_next_addr", int'(addr), 59);
    check("resume_strobe", int'(input_strobe), 1);
    pause = 1'b1;
    tick();
    tick();
    check("marker_paused_addr", int'(addr), 59);
    check("marker_paused_rev", int'(rev_count), 0);
    pause = 1'b0;
    tick();
    check("marker_resume_addr", int'(addr), 59);
    tick();
    check("marker_counted_addr", int'(addr), 0);
    check("marker_counted_rev", int'(rev_count), 1);
    check("marker_no_err", int'(wrap_err), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run_state", int'(dbg_state), int'(ST_IDLE));
    check("abort_run_done", int'(done), 0);
    check("abort_run_rev_kept", int'(rev_count), 1);

    // Abort while held with check_inputs high; start alongside is ignored.
    load_rom(59);
    rom[10][CHECK_INPUTS] = 1'b1;
    num_revs = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_pos(10, 0, "abort_reach_10");
    pause = 1'b1;
    tick();
    tick();
    check("abort_pre_state", int'(dbg_state), int'(ST_HOLD));
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; pause = 1'b0;
    check("abort_hold_state", int'(dbg_state), int'(ST_IDLE));
    check("abort_hold_busy", int'(busy), 0);
    check("abort_hold_done", int'(done), 0);
    check("abort_hold_addr", int'(addr), 0);
    check("abort_hold_strobe", int'(input_strobe), 0);
    check("abort_hold_ce_n", int'(ce_n), 1);
    check("abort_hold_oe_n", int'(oe_n), 1);
    tick();
    check("abort_start_ignored", int'(dbg_state), int'(ST_IDLE));
    check("abort_no_late_done", int'(done), 0);

    // start and abort together in IDLE stay in IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_start_abort_state", int'(dbg_state), int'(ST_IDLE));
    check("idle_start_abort_busy", int'(busy), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/drum_timing_sequencer.md
Name: drum_timing_sequencer

Overview:
- Sequencing controller for the 64-entry timing ROM that holds per-position control bits: read, write, lastRead, lastWrite, checkInputs, clearCarry and resetCounter_n.
- Drives the ROM address and enables, one drum position per clk cycle. The ROM itself selects the half-cycle phase from the clk level.
- Detects the end-of-revolution marker (resetCounter_n low) and counts revolutions.
- Runs a host-requested number of revolutions under a start/busy/done handshake, with pause and abort.

Parameters:
ADDR_W, 6, drum-position address width (64 positions)
REV_W, 8, width of the revolution request and revolution counter
TERM_ADDR, 59, the only position where resetCounter_n is legally low

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a run; sampled in IDLE only
num_revs  input  REV_W  revolutions to execute; latched on accepted start; 0 is treated as 1
pause  input  1  hold current position while high
abort  input  1  terminate the run immediately
reset_counter_n  input  1  ROM resetCounter_n bit (end-of-revolution marker, active low)
check_inputs  input  1  ROM checkInputs bit
addr  output  ADDR_W  drum position to the ROM
ce_n  output  1  ROM chip enable, active low
oe_n  output  1  ROM output enable, active low
we_n  output  1  ROM write enable; constant 1 (read-only use)
busy  output  1  high from accepted start until done or abort
done  output  1  one-cycle pulse when the requested revolutions complete
rev_count  output  REV_W  revolutions completed in the current run
input_strobe  output  1  registered check_inputs, valid only while RUN and not paused
wrap_err  output  1  sticky: marker seen at the wrong position, or addr wrapped 63->0 with no marker

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE, addr=0, ce_n=1, oe_n=1, we_n=1, busy=0, done=0, rev_count=0, input_strobe=0, wrap_err=0.
  - Reset overrides everything, including mid-run.
- FSM states: IDLE, PRIME, RUN, HOLD, FINISH.
- IDLE:
  - ce_n=1, oe_n=1.
  - start=1 and abort=0 -> PRIME: latch num_revs, addr=0, rev_count=0, clear wrap_err, busy=1.
- PRIME (exactly 1 cycle):
  - ce_n=0, oe_n=0, addr held at 0 so ROM outputs settle.
  - Next state is RUN.
- RUN:
  - Each cycle, addr increments by 1, unless reset_counter_n=0. In that case addr goes to 0 next cycle and rev_count increments.
  - If addr=63 and reset_counter_n=1, addr wraps to 0, wrap_err is set, and rev_count still increments.
  - If reset_counter_n=0 while addr!=TERM_ADDR, wrap_err is set, but the wrap is still honoured.
  - When an increment makes rev_count equal the latched target -> FINISH.
- Phase-invariant sampling:
  - Only reset_counter_n and check_inputs are sampled at the rising edge. These bits are identical in both clk phases of a position.
  - The other ROM bits are phase-dependent and are consumed directly by the datapath, never by this block.
- input_strobe = check_inputs registered, gated by RUN. Latency is 1 cycle.
- pause=1 in RUN -> HOLD:
  - addr frozen, ce_n=0, oe_n=1 (ROM outputs tri-stated), input_strobe=0, no marker sampling.
  - pause=0 -> RUN, resuming at the frozen addr.
- FINISH (1 cycle):
  - done=1, busy drops to 0 the same cycle, ce_n=1, oe_n=1, addr=0.
  - Next state is IDLE; rev_count keeps its final value until the next start.
- abort=1 in PRIME, RUN or HOLD: next cycle IDLE, busy=0, no done pulse, ce_n=oe_n=1, addr=0, rev_count retained.
- Simultaneous events:
  - abort beats pause.
  - pause beats the marker: a marker under pause is not counted.
  - start while busy is ignored.
  - start and abort together in IDLE: stay IDLE.
- Width rules:
  - rev_count never exceeds the latched target, so no overflow.
  - addr arithmetic is modulo 2^ADDR_W.

Decomposition:
- Shared package timing_pkg:
  - FSM state enum.
  - DRUM_POSITIONS=64, TERM_ADDR=59.
  - ROM bit-index constants (READ=0, WRITE=1, LAST_READ=2, LAST_WRITE=3, CHECK_INPUTS=4, CLEAR_CARRY=5, RESET_COUNTER_N=6).
- One natural sub-module, drum_position_counter: the addr register with increment, sync-clear-on-marker, hold and wrap-error detection.

Test Plan:
- Reset mid-run at addr=30: rst_n low for 1 cycle -> addr=0, ce_n=oe_n=1, busy=0, wrap_err=0 next cycle.
- Model ROM with marker at addr 59; start, num_revs=2 -> PRIME 1 cycle, addr 0..59 twice, done pulse exactly once at cycle 1+2*60, rev_count=2.
- num_revs=0 -> behaves as 1: done after 61 cycles, rev_count=1.
- Marker moved to addr 40 -> wrap occurs at 40, wrap_err=1 stays set until next start; ROM with no marker -> wrap 63->0, wrap_err=1.
- pause high for 5 cycles at addr=58 -> addr stays 58, oe_n=1, input_strobe=0; after release the marker at 59 is counted once.
- abort in HOLD at addr=10 with check_inputs high -> IDLE next cycle, no done, busy=0; a start in the same cycle as abort is ignored.
